// File: rtl/pipelined_cpu_core.sv
// Three-stage (IF, EX, WB) core for the 16-bit instruction set with parametrised data/address width.
// WB->EX forwarding, one-bubble branch flush, and handshaked memories that freeze the whole pipe.
module pipelined_cpu_core #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  input  logic              imem_ready,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ready,
  output logic              halted,
  output logic              retire,
  output logic [31:0]       retire_count
);
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_LDI  = 4'd4;
  localparam logic [3:0] OP_LD   = 4'd5;
  localparam logic [3:0] OP_ST   = 4'd6;
  localparam logic [3:0] OP_BEQ  = 4'd7;
  localparam logic [3:0] OP_JMP  = 4'd8;
  localparam logic [3:0] OP_HALT = 4'd9;

  logic [ADDR_W-1:0] pc;
  logic              fetch_stop;
  logic              ifex_valid;
  logic [15:0]       ifex_instr;
  logic [ADDR_W-1:0] ifex_pc;
  logic              exwb_valid;
  logic [3:0]        exwb_op;
  logic [2:0]        exwb_rd;
  logic [DATA_W-1:0] exwb_result;
  logic [ADDR_W-1:0] exwb_addr;
  logic [DATA_W-1:0] exwb_wdata;
  logic [DATA_W-1:0] regs [8];

  logic [3:0]        ex_op;
  logic [2:0]        ex_rd, ex_rs;
  logic [DATA_W-1:0] imm_ext, op_a, op_b, ex_result;
  logic [ADDR_W-1:0] disp_ext, ex_addr, ex_target;
  logic              ex_taken, ex_halt;
  logic              wb_is_ld, wb_mem, wb_wr, stall, wb_leave;
  logic [DATA_W-1:0] wb_value;

  assign ex_op    = ifex_instr[15:12];
  assign ex_rd    = ifex_instr[11:9];
  assign ex_rs    = ifex_instr[8:6];
  assign imm_ext  = {{(DATA_W-9){ifex_instr[8]}}, ifex_instr[8:0]};
  assign disp_ext = {{(ADDR_W-6){ifex_instr[5]}}, ifex_instr[5:0]};

  assign wb_is_ld = (exwb_op == OP_LD);
  assign wb_mem   = wb_is_ld || (exwb_op == OP_ST);
  assign wb_wr    = (exwb_op <= OP_LD);
  assign wb_value = wb_is_ld ? dmem_rdata : exwb_result;
  // A memory op waiting on dmem_ready freezes every stage, including the PC.
  assign stall    = exwb_valid && wb_mem && !dmem_ready;
  assign wb_leave = exwb_valid && !stall;

  assign op_a = (exwb_valid && wb_wr && exwb_rd == ex_rd) ? wb_value : regs[ex_rd];
  assign op_b = (exwb_valid && wb_wr && exwb_rd == ex_rs) ? wb_value : regs[ex_rs];

  always_comb begin
    ex_result = '0;
    case (ex_op)
      OP_ADD:  ex_result = op_a + op_b;
      OP_SUB:  ex_result = op_a - op_b;
      OP_AND:  ex_result = op_a & op_b;
      OP_OR:   ex_result = op_a | op_b;
      OP_LDI:  ex_result = imm_ext;
      default: ex_result = '0;
    endcase
  end

  // Address arithmetic mod 2^ADDR_W equals the DATA_W sum truncated.
  assign ex_addr   = op_b[ADDR_W-1:0] + disp_ext;
  assign ex_target = (ex_op == OP_JMP) ? op_b[ADDR_W-1:0] : ifex_pc + ADDR_W'(1) + disp_ext;
  assign ex_taken  = ifex_valid && ((ex_op == OP_BEQ && op_a == op_b) || ex_op == OP_JMP);
  assign ex_halt   = ifex_valid && (ex_op == OP_HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= ADDR_W'(RESET_PC);
      fetch_stop  <= 1'b0;
      ifex_valid  <= 1'b0;
      ifex_instr  <= '0;
      ifex_pc     <= '0;
      exwb_valid  <= 1'b0;
      exwb_op     <= '0;
      exwb_rd     <= '0;
      exwb_result <= '0;
      exwb_addr   <= '0;
      exwb_wdata  <= '0;
    end else if (!stall) begin
      exwb_valid  <= ifex_valid;
      exwb_op     <= ex_op;
      exwb_rd     <= ex_rd;
      exwb_result <= ex_result;
      exwb_addr   <= ex_addr;
      exwb_wdata  <= op_a;
      if (ex_taken) begin
        pc         <= ex_target;
        ifex_valid <= 1'b0;
      end else if (ex_halt || fetch_stop) begin
        fetch_stop <= 1'b1;
        ifex_valid <= 1'b0;
      end else if (imem_ready) begin
        ifex_valid <= 1'b1;
        ifex_instr <= imem_rdata;
        ifex_pc    <= pc;
        pc         <= pc + ADDR_W'(1);
      end else begin
        ifex_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      retire       <= 1'b0;
      retire_count <= '0;
      halted       <= 1'b0;
    end else begin
      retire <= wb_leave;
      if (wb_leave) begin
        retire_count <= retire_count + 32'd1;
        if (wb_wr) regs[exwb_rd] <= wb_value;
        if (exwb_op == OP_HALT) halted <= 1'b1;
      end
    end
  end

  assign imem_addr  = pc;
  assign dmem_req   = exwb_valid && wb_mem;
  assign dmem_we    = exwb_valid && (exwb_op == OP_ST);
  assign dmem_addr  = exwb_addr;
  assign dmem_wdata = exwb_wdata;

endmodule

// File: tb/tb_pipelined_cpu_core.sv
// Bench for pipelined_cpu_core: an instruction-level interpreter predicts the data-memory
// transaction stream and retire count; directed programs plus random programs with random stalls.
module tb_pipelined_cpu_core;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ready;
  logic        dmem_req, dmem_we;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ready;
  logic        halted, retire;
  logic [31:0] retire_count;

  logic [11:0] w_imem_addr, w_dmem_addr;
  logic [15:0] w_imem_rdata;
  logic        w_dmem_req, w_dmem_we, w_halted, w_retire;
  logic [31:0] w_dmem_wdata, w_retire_count;

  always #5 clk = ~clk;

  pipelined_cpu_core #(.DATA_W(16), .ADDR_W(16), .RESET_PC(0)) u_dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready), .halted(halted), .retire(retire),
    .retire_count(retire_count));

  // Wide variant: LDI r3,-1 ; ST r3,-1(r0) ; HALT
  pipelined_cpu_core #(.DATA_W(32), .ADDR_W(12), .RESET_PC(0)) u_dut_wide (
    .clk(clk), .rst(rst), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
    .imem_ready(1'b1), .dmem_req(w_dmem_req), .dmem_we(w_dmem_we),
    .dmem_addr(w_dmem_addr), .dmem_wdata(w_dmem_wdata), .dmem_rdata(32'h0),
    .dmem_ready(1'b1), .halted(w_halted), .retire(w_retire),
    .retire_count(w_retire_count));

  always_comb begin
    case (w_imem_addr)
      12'd0:   w_imem_rdata = 16'h47FF;
      12'd1:   w_imem_rdata = 16'h663F;
      default: w_imem_rdata = 16'h9000;
    endcase
  end

  logic [15:0] imem [0:255];
  logic [15:0] dmem [0:65535];
  logic        mem_init, poke_en;
  logic [15:0] poke_addr, poke_val;

  int tests, fails;
  int imem_mode, ipct, dpct, dhold_cfg, dhold;
  int m_count, m_taken, wide_seen;
  bit          q_we [$];
  logic [15:0] q_addr [$];
  logic [15:0] q_data [$];
  logic [15:0] mdm [logic [15:0]];

  function automatic logic [15:0] init_val(input int i);
    return 16'(i) ^ 16'h5A5A;
  endfunction

  always_comb imem_rdata = (imem_addr < 16'd256) ? imem[imem_addr[7:0]] : 16'h9000;
  always_comb dmem_rdata = dmem[dmem_addr];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 65536; i++) dmem[i] <= init_val(i);
      if (poke_en) dmem[poke_addr] <= poke_val;
    end else if (!rst && dmem_req && dmem_we && dmem_ready) begin
      dmem[dmem_addr] <= dmem_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [15:0] a);
    if (mdm.exists(a)) return mdm[a];
    return init_val(int'(a));
  endfunction

  // Architectural interpreter: one instruction per step, no pipeline notion.
  task automatic run_model();
    logic [15:0] r [8];
    logic [15:0] pc, npc, ins, a, b, dsp, ea;
    bit done;
    int steps;
    for (int i = 0; i < 8; i++) r[i] = '0;
    mdm.delete();
    if (poke_en) mdm[poke_addr] = poke_val;
    q_we.delete(); q_addr.delete(); q_data.delete();
    pc = '0; m_count = 0; m_taken = 0; done = 0; steps = 0;
    while (!done && steps < 2000) begin
      ins = (pc < 16'd256) ? imem[pc[7:0]] : 16'h9000;
      a   = r[ins[11:9]];
      b   = r[ins[8:6]];
      dsp = {{10{ins[5]}}, ins[5:0]};
      ea  = b + dsp;
      npc = pc + 16'd1;
      m_count++;
      steps++;
      case (ins[15:12])
        4'd0: r[ins[11:9]] = a + b;
        4'd1: r[ins[11:9]] = a - b;
        4'd2: r[ins[11:9]] = a & b;
        4'd3: r[ins[11:9]] = a | b;
        4'd4: r[ins[11:9]] = {{7{ins[8]}}, ins[8:0]};
        4'd5: begin
          q_we.push_back(1'b0); q_addr.push_back(ea); q_data.push_back(16'h0);
          r[ins[11:9]] = model_read(ea);
        end
        4'd6: begin
          q_we.push_back(1'b1); q_addr.push_back(ea); q_data.push_back(a);
          mdm[ea] = a;
        end
        4'd7: if (a == b) begin npc = pc + 16'd1 + dsp; m_taken++; end
        4'd8: begin npc = b; m_taken++; end
        4'd9: done = 1;
        default: ;
      endcase
      pc = npc;
    end
  endtask

  task automatic compare_loop();
    int ret_seen;
    bit prev_stall;
    logic [15:0] prev_iaddr;
    bit ew;
    logic [15:0] ea, ed;
    ret_seen = 0; prev_stall = 0; prev_iaddr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ret_seen = 0; prev_stall = 0;
      end else begin
        if (dmem_req && dmem_ready) begin
          tests++;
          if (q_we.size() == 0) begin
            fails++;
            $display("FAIL dmem_extra: got we=%0d addr=%0h data=%0h expected no access", dmem_we, dmem_addr, dmem_wdata);
          end else begin
            ew = q_we.pop_front(); ea = q_addr.pop_front(); ed = q_data.pop_front();
            if (dmem_we !== ew || dmem_addr !== ea || (ew && dmem_wdata !== ed)) begin
              fails++;
              $display("FAIL dmem_access: got we=%0d addr=%0h data=%0h expected we=%0d addr=%0h data=%0h",
                       dmem_we, dmem_addr, dmem_wdata, ew, ea, ed);
            end
          end
        end
        if (prev_stall) begin
          tests++;
          if (imem_addr !== prev_iaddr) begin
            fails++;
            $display("FAIL stall_pc_hold: got %0h expected %0h", imem_addr, prev_iaddr);
          end
        end
        prev_stall = dmem_req && !dmem_ready;
        prev_iaddr = imem_addr;
        if (retire) begin
          ret_seen++;
          tests++;
          if (retire_count !== 32'(ret_seen)) begin
            fails++;
            $display("FAIL retire_count_step: got %0d expected %0d", retire_count, ret_seen);
          end
        end
        if (w_dmem_req) begin
          wide_seen++;
          tests++;
          if (w_dmem_we !== 1'b1 || w_dmem_addr !== 12'hFFF || w_dmem_wdata !== 32'hFFFF_FFFF) begin
            fails++;
            $display("FAIL wide_store: got we=%0d addr=%0h data=%0h expected we=1 addr=fff data=ffffffff",
                     w_dmem_we, w_dmem_addr, w_dmem_wdata);
          end
        end
      end
    end
  endtask

  task automatic drive_loop();
    forever begin
      @(posedge clk);
      #1;
      if (imem_mode == 0) imem_ready = ($urandom_range(99) < ipct);
      else                imem_ready = ~imem_ready;
      if (rst) begin
        dhold = dhold_cfg;
        dmem_ready = 1'b1;
      end else if (dmem_req && dhold > 0) begin
        dmem_ready = 1'b0;
        dhold--;
      end else begin
        dmem_ready = ($urandom_range(99) < dpct);
      end
    end
  endtask

  task automatic prep_prog();
    rst = 1'b1;
    mem_init = 1'b1;
    @(posedge clk);
    #2 mem_init = 1'b0;
    @(posedge clk);
    run_model();
  endtask

  task automatic exec_prog(input int exp_cycles, input int budget);
    int cyc;
    logic [15:0] frozen;
    @(posedge clk);
    #2 rst = 1'b0;
    cyc = 0;
    while (!halted && cyc < budget) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    check("halt_reached", 32'(halted), 32'd1);
    if (exp_cycles >= 0) check("cycles_to_halt", cyc, exp_cycles);
    check("retire_total", retire_count, m_count);
    check("dmem_pending", q_we.size(), 0);
    frozen = imem_addr;
    repeat (20) begin
      @(posedge clk);
      #2;
      check("halt_pc_frozen", 32'(imem_addr), 32'(frozen));
      check("halt_no_retire", 32'(retire), 32'd0);
    end
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 256; i++) imem[i] = 16'h9000;
  endtask

  task automatic gen_random();
    logic [2:0] rd, rs;
    fill_nop();
    for (int i = 0; i < 30; i++) begin
      rd = 3'($urandom_range(7));
      rs = 3'($urandom_range(7));
      case ($urandom_range(9))
        0:       imem[i] = {4'h0, rd, rs, 6'h0};
        1:       imem[i] = {4'h1, rd, rs, 6'h0};
        2:       imem[i] = {4'h2, rd, rs, 6'h0};
        3:       imem[i] = {4'h3, rd, rs, 6'h0};
        4, 5:    imem[i] = {4'h4, rd, 9'($urandom)};
        6:       imem[i] = {4'h5, rd, rs, 6'($urandom)};
        7:       imem[i] = {4'h6, rd, rs, 6'($urandom)};
        8:       imem[i] = {4'h7, rd, rs, 6'($urandom_range(5))};
        default: imem[i] = {4'($urandom_range(15, 10)), 12'($urandom)};
      endcase
    end
    for (int i = 30; i < 36; i++) imem[i] = 16'hA000;
    for (int i = 0; i < 8; i++) imem[36+i] = {4'h6, 3'(i), 3'h0, 6'(i)};
    imem[44] = 16'h9000;
  endtask

  initial begin
    tests = 0; fails = 0; wide_seen = 0;
    rst = 1'b1; mem_init = 1'b0; poke_en = 1'b0; poke_addr = '0; poke_val = '0;
    imem_mode = 0; ipct = 100; dpct = 100; dhold_cfg = 0; dhold = 0;
    imem_ready = 1'b1; dmem_ready = 1'b1;
    fork
      compare_loop();
      drive_loop();
    join_none

    repeat (2) @(posedge clk);
    #2;
    check("reset_imem_addr", 32'(imem_addr), 32'd0);
    check("reset_dmem_req", 32'(dmem_req), 32'd0);
    check("reset_retire_count", retire_count, 32'd0);
    check("reset_halted", 32'(halted), 32'd0);

    // Forwarding chain, zero-wait: LDI r1,5 ; LDI r2,-3 ; ADD r1,r2 ; ST r1,0(r0) ; HALT
    fill_nop();
    imem[0] = 16'h4205; imem[1] = 16'h45FD; imem[2] = 16'h0280; imem[3] = 16'h6200;
    prep_prog();
    check("model1_count", m_count, 32'd5);
    check("model1_addr", 32'(q_addr[0]), 32'd0);
    check("model1_data", 32'(q_data[0]), 32'd2);
    exec_prog(7, 200);

    // Load stalled 3 cycles, then load-use ADD and store of the doubled value
    fill_nop();
    imem[0] = 16'h5802; imem[1] = 16'h0900; imem[2] = 16'h6800;
    poke_en = 1'b1; poke_addr = 16'd2; poke_val = 16'h1234; dhold_cfg = 3;
    prep_prog();
    check("model3_data", 32'(q_data[1]), 32'h2468);
    exec_prog(9, 200);
    poke_en = 1'b0; dhold_cfg = 0;

    // Taken BEQ at PC 10, not-taken BEQ at 13, JMP 15 -> 17
    fill_nop();
    imem[0] = 16'h4207; imem[1] = 16'h4407;
    for (int i = 2; i < 10; i++) imem[i] = 16'hA000;
    imem[10] = 16'h7282; imem[11] = 16'h6200; imem[12] = 16'h6201; imem[13] = 16'h7201;
    imem[14] = 16'h4611; imem[15] = 16'h80C0; imem[16] = 16'h6203; imem[17] = 16'h6402;
    prep_prog();
    check("model4_count", m_count, 32'd16);
    check("model4_taken", m_taken, 32'd2);
    check("model4_stores", q_we.size(), 32'd1);
    exec_prog(20, 200);

    // Toggling fetch readiness with HALT at PC 5
    fill_nop();
    for (int i = 0; i < 5; i++) imem[i] = 16'hA000;
    imem_mode = 1;
    prep_prog();
    exec_prog(-1, 200);
    check("halt_pc_value", 32'(imem_addr), 32'd6);
    imem_mode = 0;

    // Reset in the middle of a stalled load
    fill_nop();
    imem[0] = 16'h4205; imem[1] = 16'h5802;
    dhold_cfg = 1000;
    prep_prog();
    @(posedge clk);
    #2 rst = 1'b0;
    for (int c = 0; c < 50 && !(dmem_req && !dmem_ready); c++) begin
      @(posedge clk);
      #2;
    end
    check("mid_access_stalled", 32'(dmem_req && !dmem_ready), 32'd1);
    check("mid_access_retired", retire_count, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_reset_dmem_req", 32'(dmem_req), 32'd0);
    check("mid_reset_imem_addr", 32'(imem_addr), 32'd0);
    check("mid_reset_halted", 32'(halted), 32'd0);
    check("mid_reset_retire_count", retire_count, 32'd0);
    dhold_cfg = 0;
    prep_prog();
    check("model6_count", m_count, 32'd3);
    exec_prog(5, 200);

    // Random programs under random fetch and data wait states
    for (int t = 0; t < 8; t++) begin
      ipct = 40 + 8 * t;
      dpct = 100 - 8 * t;
      gen_random();
      prep_prog();
      exec_prog(-1, 4000);
    end

    check("wide_store_seen", 32'(wide_seen > 0), 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
